// File: rtl/dcm_pkg.sv
// Shared constants and the program-code to divisor table for the clock manager.
package dcm_pkg;

    localparam int unsigned PROG_W = 3;
    localparam int unsigned DIV_W  = 9;

    localparam logic [PROG_W-1:0] PROG_BYPASS = '0;

    // Code 0 bypasses the channel divider, so its table entry is never used.
    function automatic logic [DIV_W-1:0] prog_to_div(input logic [PROG_W-1:0] code);
        logic [DIV_W-1:0] div;
        case (code)
            3'd1:    div = 9'd1;
            3'd2:    div = 9'd2;
            3'd3:    div = 9'd5;
            3'd4:    div = 9'd8;
            3'd5:    div = 9'd16;
            3'd6:    div = 9'd32;
            3'd7:    div = 9'd64;
            default: div = 9'd0;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/dcm_multi_if.sv
// Update request/acknowledge bus and program readback for the multi-channel clock manager.
interface dcm_multi_if
    import dcm_pkg::*;
#(
    parameter int unsigned N_CH = 4
);

    localparam int unsigned UPD_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     update;
    logic [UPD_W-1:0]         upd_ch;
    logic [PROG_W-1:0]        prog_in;
    logic                     upd_ack;
    logic [N_CH*PROG_W-1:0]   prog_out;

    modport master (
        output update,
        output upd_ch,
        output prog_in,
        input  upd_ack,
        input  prog_out
    );

    modport slave (
        input  update,
        input  upd_ch,
        input  prog_in,
        output upd_ack,
        output prog_out
    );

endinterface

// File: rtl/dcm_channel.sv
// One programmable channel: divides the base wave by a table divisor, or passes it through.
module dcm_channel
    import dcm_pkg::*;
#(
    parameter int unsigned CNT_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_out,
    input  logic              base_rise,
    input  logic              load,
    input  logic [PROG_W-1:0] prog_in,
    output logic [PROG_W-1:0] prog,
    output logic              ch_out,
    output logic              ch_tick
);

    logic [PROG_W-1:0] prog_q, prog_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ch_q, ch_d;
    logic              out_prev_q;
    logic              tick_q;
    logic [CNT_W-1:0]  div;

    assign div     = CNT_W'(prog_to_div(prog_q));
    assign prog    = prog_q;
    assign ch_out  = (prog_q == PROG_BYPASS) ? base_out : ch_q;
    assign ch_tick = tick_q;

    // A load takes priority over a coincident base rise; that count step is dropped.
    always_comb begin
        prog_d = prog_q;
        cnt_d  = cnt_q;
        ch_d   = ch_q;
        if (load) begin
            prog_d = prog_in;
            cnt_d  = CNT_W'(1);
            ch_d   = ~ch_q;
        end else if (base_rise && (prog_q != PROG_BYPASS)) begin
            if (cnt_q == div) begin
                ch_d  = ~ch_q;
                cnt_d = CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_q     <= PROG_BYPASS;
            cnt_q      <= CNT_W'(1);
            ch_q       <= 1'b0;
            out_prev_q <= 1'b1;
            tick_q     <= 1'b0;
        end else begin
            prog_q     <= prog_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            out_prev_q <= ch_out;
            tick_q     <= ch_out ^ out_prev_q;
        end
    end

endmodule

// File: rtl/dcm_multi.sv
// Multi-channel clock manager: base divider, update decode and N_CH programmable channels,
// all running as enables in the clk domain.
module dcm_multi
    import dcm_pkg::*;
#(
    parameter int unsigned BASE_HALF = 5_000_000,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CNT_W     = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    dcm_multi_if.slave      bus,
    output logic            base_out,
    output logic            base_rise,
    output logic [N_CH-1:0] ch_out,
    output logic [N_CH-1:0] ch_tick
);

    localparam int unsigned UPD_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned BASE_W = (BASE_HALF > 1) ? $clog2(BASE_HALF) : 1;

    logic [BASE_W-1:0]      base_cnt_q;
    logic                   base_q;
    logic                   base_prev_q;
    logic                   base_rise_q;
    logic                   ack_q;
    logic                   upd_valid;
    logic [N_CH-1:0]        load;
    logic [N_CH*PROG_W-1:0] prog_all;

    assign base_out     = base_q;
    assign base_rise    = base_rise_q;
    assign bus.upd_ack  = ack_q;
    assign bus.prog_out = prog_all;

    // Out-of-range channel numbers are ignored entirely: no load and no ack.
    assign upd_valid = bus.update && (32'(bus.upd_ch) < N_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_cnt_q  <= '0;
            base_q      <= 1'b1;
            base_prev_q <= 1'b1;
            base_rise_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            if (base_cnt_q == BASE_W'(BASE_HALF - 1)) begin
                base_cnt_q <= '0;
                base_q     <= ~base_q;
            end else begin
                base_cnt_q <= base_cnt_q + BASE_W'(1);
            end
            base_prev_q <= base_q;
            base_rise_q <= base_q & ~base_prev_q;
            ack_q       <= upd_valid;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign load[i] = upd_valid && (bus.upd_ch == UPD_W'(i));

        dcm_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .base_out  (base_q),
            .base_rise (base_rise_q),
            .load      (load[i]),
            .prog_in   (bus.prog_in),
            .prog      (prog_all[i*PROG_W +: PROG_W]),
            .ch_out    (ch_out[i]),
            .ch_tick   (ch_tick[i])
        );
    end

endmodule

// File: doc/dcm_multi.md
Name: dcm_multi

Overview:
- Parametrised, multi-channel successor to the single-channel programmable clock manager.
- A base divider turns the system clock into a slow base square wave plus single-cycle strobes.
- N_CH independent channels each divide the base wave by a per-channel programmable code and produce a square wave and a toggle strobe.
- Everything runs in the clk domain: channels use enables, not derived clocks. The block sits between the board clock and the display/sequencer logic.

Parameters:
- BASE_HALF, 5_000_000: clk cycles per base half-period (10 Hz base from 100 MHz).
- N_CH, 4: number of programmable channels (1..8).
- PROG_W, 3: width of a program code (fixed at 3 by the table in dcm_pkg).
- CNT_W, 9: width of the channel counter; must hold the largest divisor (64).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- update  in  1  single-cycle request to load prog_in into channel upd_ch.
- upd_ch  in  max(1,$clog2(N_CH))  target channel of the update.
- prog_in  in  PROG_W  program code to load.
- upd_ack  out  1  one-cycle pulse, the cycle after an accepted update.
- prog_out  out  N_CH*PROG_W  current code of each channel; channel i is at bits [i*PROG_W +: PROG_W].
- base_out  out  1  base square wave.
- base_rise  out  1  one-cycle strobe on the cycle base_out goes 0->1.
- ch_out  out  N_CH  per-channel square wave.
- ch_tick  out  N_CH  per-channel one-cycle strobe on each ch_out toggle.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - base counter = 0, base_out = 1, base_rise = 0.
  - All channels: prog = 0, cnt = 1, ch_q = 0.
  - upd_ack = 0, ch_tick = 0.
  - Releasing rst_n mid-period restarts all of these from the values above.
- Base divider:
  - Counter runs 0..BASE_HALF-1. At BASE_HALF-1 it wraps to 0 and base_out toggles on that edge.
  - base_rise is high in the cycle immediately after base_out becomes 1.
  - Base period is 2*BASE_HALF clk cycles.
- Divisor table, code -> D: 0->bypass, 1->1, 2->2, 3->5, 4->8, 5->16, 6->32, 7->64.
- Channel counting, on each base_rise with prog != 0:
  - If cnt == D: ch_q toggles, cnt = 1.
  - Otherwise: cnt increments.
  - ch_q therefore toggles every D base rises.
- Channel output:
  - ch_out = base_out when prog == 0, else ch_q.
  - ch_tick[i] is high in the cycle after ch_out[i] changes; this covers the bypass case too.
- Update handshake:
  - Sampled on a clk edge with update = 1 and upd_ch < N_CH.
  - Target channel: prog = prog_in, cnt = 1, ch_q toggles.
  - upd_ack pulses in the next cycle.
  - Other channels are unaffected.
  - upd_ch >= N_CH: no state change, no ack.
  - Update held high: reloads and toggles every cycle; callers drive a single-cycle pulse.
- Simultaneous events:
  - Update and base_rise on the same channel in the same cycle: the update wins and the count advance is dropped.
  - Update on one channel and base_rise on others: the other channels count normally.
- Width rules:
  - cnt compares against D zero-extended to CNT_W.
  - cnt never exceeds D, because an update resets it to 1.
  - No arithmetic overflow is possible.

Decomposition:
- dcm_pkg holds:
  - PROG_W.
  - The divisor table as a function prog_to_div(code) returning CNT_W bits.
  - The code constant PROG_BYPASS = 0.
- Sub-module dcm_channel, instantiated N_CH times via generate:
  - Inputs: clk, rst_n, base_out, base_rise, load, prog_in.
  - Outputs: prog, ch_out, ch_tick.
- The top level keeps the base divider, upd_ch decode and upd_ack.

Test Plan:
- Reset, BASE_HALF=4, N_CH=2 -> base_out=1, all ch_out=base_out, prog_out=0. base_out falls at clk 4 and rises at clk 8. base_rise is high at clk 9.
- Update ch0 with code 1 -> upd_ack pulses for 1 cycle and ch0 toggles immediately. Afterwards ch0 toggles every base rise: period 16 clk, ch_tick once per toggle. ch1 still follows base_out.
- Update ch1 with code 3 -> ch1 toggles every 5 base rises (40 clk, period 80). prog_out[5:3]=3, prog_out[2:0]=1 unchanged.
- Update landing in the same cycle as base_rise on ch0 -> cnt=1 and ch0 toggles once, not twice. The next toggle comes after D further rises.
- update with upd_ch=3 on N_CH=2 -> no ack and prog_out unchanged.
- rst_n asserted low mid-count, with codes 7 and 5 loaded -> all outputs return to reset values immediately. After release, the base timing matches the first scenario.
